// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit combinational ALU: 4x8 register file, IDLE/EXEC/DONE sequencing.
// Optional illegal-op trap enabled by defining ALU_SEQ_ILLEGAL_TRAP_EN; otherwise illegal ops complete as NOPs.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [2:0] alu_mode,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    state_t     state_r;
    logic [7:0] regs_r [4];
    logic [2:0] op_r;
    logic [1:0] ra_r;
    logic [1:0] rb_r;
    logic       flag_zero_r;
    logic       flag_carry_r;
    logic       done_r;
    logic       unused_reserved_s;

    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign unused_reserved_s = instr[4];
    assign instr_ready       = (state_r == ST_IDLE);
    assign rd_data           = regs_r[rd_addr];
    assign flag_zero         = flag_zero_r;
    assign flag_carry        = flag_carry_r;
    assign done              = done_r;

    // Sequencer FSM, register file, flag capture and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            for (int i = 0; i < 4; i++) regs_r[i] <= 8'h00;
            op_r         <= 3'd0;
            ra_r         <= 2'd0;
            rb_r         <= 2'd0;
            flag_zero_r  <= 1'b0;
            flag_carry_r <= 1'b0;
            done_r       <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            err_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // A same-cycle load commits before EXEC reads the file.
                    if (ld_en) regs_r[ld_addr] <= ld_data;
                    if (instr_valid) begin
                        op_r    <= instr[7:5];
                        ra_r    <= instr[3:2];
                        rb_r    <= instr[1:0];
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                    case (op_r)
                        OP_ADD, OP_SUB: begin
                            regs_r[ra_r] <= alu_out;
                            flag_zero_r  <= alu_zero;
                            flag_carry_r <= alu_carry;
                        end
                        OP_CMP: begin
                            flag_zero_r  <= alu_zero;
                            flag_carry_r <= alu_carry;
                        end
                        // Logic ops leave carry alone; the ALU carry is stale here.
                        OP_AND, OP_OR, OP_XOR: begin
                            regs_r[ra_r] <= alu_out;
                            flag_zero_r  <= alu_zero;
                        end
                        default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                            err_r <= 1'b1;
`endif
                        end
                    endcase
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU drive: operands and mode only for a legal op in EXEC, zeros otherwise.
    always_comb begin
        alu_in1  = 8'h00;
        alu_in2  = 8'h00;
        alu_mode = 3'b000;
        if ((state_r == ST_EXEC) && op_legal(op_r)) begin
            alu_in1  = regs_r[ra_r];
            alu_in2  = regs_r[rb_r];
            alu_mode = op_r;
        end else begin
            alu_in1  = 8'h00;
            alu_in2  = 8'h00;
            alu_mode = 3'b000;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural combinational ALU responder.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [2:0] alu_mode;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_carry;
    logic       flag_zero;
    logic       flag_carry;
    logic       done;
    logic       err;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .done(done), .err(err)
    );

    always #5 clk = ~clk;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [1:0] ra;
        logic [7:0] val;
        logic       fz;
        logic       fc;
        logic       er;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_regs [4];
    logic       m_fz, m_fc, m_err;
    logic       junk_carry = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    // Behavioural ALU; carry for logic ops is deliberately junk.
    always_comb begin
        logic [8:0] s9;
        s9        = 9'd0;
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_mode)
            3'd0: begin s9 = {1'b0, alu_in1} + {1'b0, alu_in2}; alu_out = s9[7:0]; alu_carry = s9[8]; end
            3'd1, 3'd2: begin alu_out = alu_in2 - alu_in1; alu_carry = (alu_in1 > alu_in2); end
            3'd3: begin alu_out = alu_in1 & alu_in2; alu_carry = junk_carry; end
            3'd4: begin alu_out = alu_in1 | alu_in2; alu_carry = junk_carry; end
            3'd5: begin alu_out = alu_in1 ^ alu_in2; alu_carry = junk_carry; end
            default: begin alu_out = 8'h00; alu_carry = junk_carry; end
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0];
            #1;
            chk_eq(tag, {24'd0, rd_data}, {24'd0, m_regs[i]});
        end
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        m_regs[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic same_ld, input logic [1:0] la, input logic [7:0] ld,
                         input logic exec_ld);
        logic [7:0] a, b;
        logic [8:0] s9;
        logic       legal;
        int         waitc;
        exp_t       e;
        @(negedge clk);
        waitc = 0;
        while (!instr_ready && waitc < 8) begin @(negedge clk); waitc++; end
        chk_eq("ready_idle", {31'd0, instr_ready}, 32'd1);
        instr = {op, 1'b0, ra, rb};
        instr_valid = 1'b1;
        if (same_ld) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; m_regs[la] = ld; end
        a = m_regs[ra]; b = m_regs[rb];
        junk_carry = ~m_fc;
        legal = (op <= 3'd5);
        case (op)
            3'd0: begin s9 = {1'b0, a} + {1'b0, b}; m_regs[ra] = s9[7:0]; m_fz = (s9[7:0] == 8'h00); m_fc = s9[8]; end
            3'd1: begin m_regs[ra] = b - a; m_fz = (a == b); m_fc = (a > b); end
            3'd2: begin m_fz = (a == b); m_fc = (a > b); end
            3'd3: begin m_regs[ra] = a & b; m_fz = ((a & b) == 8'h00); end
            3'd4: begin m_regs[ra] = a | b; m_fz = ((a | b) == 8'h00); end
            3'd5: begin m_regs[ra] = a ^ b; m_fz = ((a ^ b) == 8'h00); end
            default: m_err = m_err | TRAP;
        endcase
        e.ra = ra; e.val = m_regs[ra]; e.fz = m_fz; e.fc = m_fc; e.er = m_err;
        sb.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0; ld_en = 1'b0;
        chk_eq("exec_ready", {31'd0, instr_ready}, 32'd0);
        chk_eq("exec_mode", {29'd0, alu_mode}, legal ? {29'd0, op} : 32'd0);
        chk_eq("exec_in1", {24'd0, alu_in1}, legal ? {24'd0, a} : 32'd0);
        chk_eq("exec_in2", {24'd0, alu_in2}, legal ? {24'd0, b} : 32'd0);
        if (exec_ld) begin ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h7F; end
        waitc = 0;
        @(negedge clk);
        while (!done && waitc < 4) begin @(negedge clk); waitc++; end
        ld_en = 1'b0;
        chk_eq("done_latency", waitc, 32'd0);
        chk_eq("done_ready", {31'd0, instr_ready}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.ra;
            #1;
            chk_eq("result", {24'd0, rd_data}, {24'd0, e.val});
            chk_eq("flag_zero", {31'd0, flag_zero}, {31'd0, e.fz});
            chk_eq("flag_carry", {31'd0, flag_carry}, {31'd0, e.fc});
            chk_eq("err", {31'd0, err}, {31'd0, e.er});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rdy_pat, done_pat;
        rst = 1'b1; instr_valid = 1'b0; instr = 8'h00;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; rd_addr = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_fz = 1'b0; m_fc = 1'b0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        chk_eq("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        chk_eq("rst_err", {31'd0, err}, 32'd0);
        chk_eq("rst_drive", {13'd0, alu_mode, alu_in1, alu_in2}, 32'd0);
        check_regs("rst_regs");

        // add with carry
        do_load(2'd0, 8'hF0); do_load(2'd1, 8'h20);
        issue(3'd0, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);
        // sub to zero, then sub with borrow
        do_load(2'd0, 8'h05); do_load(2'd1, 8'h05);
        issue(3'd1, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);
        do_load(2'd0, 8'h06);
        issue(3'd1, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);
        // compare then xor with itself
        do_load(2'd2, 8'h30); do_load(2'd3, 8'h10);
        issue(3'd2, 2'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0);
        check_regs("cmp_regs");
        issue(3'd5, 2'd2, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0);
        // load during EXEC ignored; load with handshake used
        issue(3'd4, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1);
        check_regs("exec_ld_regs");
        issue(3'd0, 2'd1, 2'd1, 1'b1, 2'd1, 8'h41, 1'b0);
        // illegal op
        issue(3'd6, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);
        check_regs("illegal_regs");

        // valid held high across back-to-back ANDs of R3 with itself
        do_load(2'd3, 8'h5A);
        @(negedge clk);
        instr = {3'd3, 1'b0, 2'd3, 2'd3};
        instr_valid = 1'b1;
        junk_carry = ~m_fc;
        rdy_pat = 6'b100100; done_pat = 6'b010010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_eq("b2b_ready", {31'd0, instr_ready}, {31'd0, rdy_pat[k]});
            chk_eq("b2b_done", {31'd0, done}, {31'd0, done_pat[k]});
        end
        instr_valid = 1'b0;
        m_fz = (m_regs[3] == 8'h00);
        chk_eq("b2b_flags", {30'd0, flag_zero, flag_carry}, {30'd0, m_fz, m_fc});
        check_regs("b2b_regs");

        // random mix
        for (int n = 0; n < 20; n++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom), 1'b0);
        end
        check_regs("rand_regs");

        // reset mid-EXEC
        do_load(2'd2, 8'hFF);
        @(negedge clk);
        instr = {3'd0, 1'b0, 2'd2, 2'd2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_fz = 1'b0; m_fc = 1'b0; m_err = 1'b0;
        chk_eq("mrst_ready", {31'd0, instr_ready}, 32'd1);
        chk_eq("mrst_done", {31'd0, done}, 32'd0);
        chk_eq("mrst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        chk_eq("mrst_err", {31'd0, err}, 32'd0);
        check_regs("mrst_regs");
        @(negedge clk);
        chk_eq("mrst_nodone", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
